ev21g1_run_ctrl: RTL
====================

// Module: ev21g1_run_ctrl
// PURPOSE
//  Run controller placed between the board clock/reset and the ev21g1 CPU core.
//  - Sequences the CPU reset for a programmable number of clocks.
//  - Gates CPU execution with a clock enable, in one of three modes: free-run, bounded run or single-step.
//  - Counts executed cycles.
//  - Halts on user stop, cycle budget or an output-port watchpoint.
//  - Gives an on-chip equivalent of the bench reset/clock sequencing, with debug control added.
// PARAMETERS
//  RESET_CYCLES  4   clocks cpu_reset is held low after reset or a rerun (>=1)
//  CNT_W         32  width of cycle counter and run_cycles
//  DATA_W        32  width of the watched CPU output port
// PORTS
//  clk          in   1       system clock
//  reset        in   1       async, active-low system reset
//  start        in   1       1-clk pulse: begin run (IDLE) / rerun with CPU reset (HALTED)
//  step         in   1       1-clk pulse: execute exactly one CPU cycle (IDLE only)
//  stop         in   1       1-clk pulse: halt a run
//  mode         in   1       0=free-run, 1=bounded; sampled on start
//  run_cycles   in   CNT_W   cycle budget; sampled on start
//  watch_en     in   1       enable watchpoint
//  watch_value  in   DATA_W  watchpoint compare value
//  watch_port   in   DATA_W  CPU output_port0
//  cpu_reset    out  1       active-low reset to CPU core (registered)
//  cpu_clk_en   out  1       CPU clock enable
//  cycle_count  out  CNT_W   enabled cycles since last CPU reset
//  busy         out  1       state is RUN or STEP
//  done         out  1       state is HALTED
//  halt_cause   out  2       0=none, 1=user stop, 2=watchpoint, 3=budget
// BEHAVIOUR
//  - Reset (async, reset=0) values: state=RST_HOLD, hold_cnt=0, cpu_reset=0, cycle_count=0, halt_cause=0, run_cycles_q=0, mode_q=0.
//  - cpu_clk_en, busy and done are decoded from the registered state only (Moore, glitch-free).
//  - States: RST_HOLD, IDLE, RUN, STEP, HALTED.
//  - RST_HOLD:
//    - cpu_reset=0, cpu_clk_en=0; hold_cnt increments every clk.
//    - When hold_cnt==RESET_CYCLES-1, go to IDLE and set cpu_reset=1 on the same edge.
//    - start, step and stop are ignored.
//  - IDLE:
//    - start latches mode_q and run_cycles_q and goes to RUN, unless mode=1 and run_cycles=0: then HALTED with cause 3 and zero enabled cycles.
//    - Otherwise step goes to STEP. start wins over step. stop is ignored.
//  - RUN: cpu_clk_en=1; cycle_count increments (saturates at all-ones) on every edge spent in RUN or STEP. Exit conditions at each RUN edge, in priority order:
//    1. stop -> HALTED, cause 1.
//    2. watch_en && watch_port==watch_value -> HALTED, cause 2.
//    3. mode_q==1 && cycle_count+1==run_cycles_q -> HALTED, cause 3.
//    - Every cycle spent in RUN, including the halting cycle, is counted.
//    - A bounded run therefore enables exactly run_cycles cycles.
//  - STEP: cpu_clk_en=1 for exactly one clk, then IDLE. stop, start and step are ignored.
//  - HALTED:
//    - cpu_clk_en=0; halt_cause holds its value.
//    - start -> RST_HOLD: clears hold_cnt, cycle_count and halt_cause; drives cpu_reset=0.
//    - step and stop are ignored.
//  - Latency: start sampled at edge k; cpu_clk_en is high in the cycle after edge k. step gives one enabled cycle after its sampling edge.
//  - reset asserted mid-run: immediate return to reset values; cpu_clk_en drops asynchronously.
//  - Watch comparison is combinational on watch_port at the sampling edge; it is not evaluated in STEP.
// STRUCTURE
//  - Shared package ev21g1_pkg: state encoding localparams ST_RST_HOLD..ST_HALTED, and HALT_NONE/USER/WATCH/BUDGET constants.
//  - One sub-module: ev21g1_sat_counter (parametrised width, enable, synchronous clear, saturation). Used for both hold_cnt and cycle_count.
//  - All else is a single FSM always block plus output decode.
// TESTING
//  1. Reset and hold: release reset -> cpu_reset=0 for exactly 4 clks, then 1; state=IDLE; cycle_count=0.
//  2. Bounded run: mode=1, run_cycles=10, start -> cpu_clk_en high for exactly 10 clks; done=1; halt_cause=3; cycle_count=10.
//  3. Watchpoint: mode=0, watch_en=1, watch_value=32'h0000_00A5; drive watch_port=A5 on the 7th RUN clk -> halt, cause 2, cycle_count=7.
//  4. Priority: stop and watch match on the same edge -> cause 1. Then start in HALTED -> cpu_reset low 4 clks, cycle_count=0.
//  5. Step and corner cases:
//     - 3 step pulses in IDLE -> 3 single enabled clks, cycle_count=3.
//     - start+step together -> RUN.
//     - mode=1, run_cycles=0 -> HALTED immediately, cause 3, cycle_count=0.
//  6. Async reset mid-RUN at cycle 5 -> cpu_clk_en=0 and cpu_reset=0 without a clock edge; all outputs at reset values.

Source files
------------

// File: rtl/ev21g1_pkg.sv
// Shared definitions for the ev21g1 run controller: FSM state encoding and
// halt-cause codes reported to the debug host.
package ev21g1_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD = 3'd0,
    ST_IDLE     = 3'd1,
    ST_RUN      = 3'd2,
    ST_STEP     = 3'd3,
    ST_HALTED   = 3'd4
  } state_t;

  localparam logic [1:0] HALT_NONE   = 2'd0;
  localparam logic [1:0] HALT_USER   = 2'd1;
  localparam logic [1:0] HALT_WATCH  = 2'd2;
  localparam logic [1:0] HALT_BUDGET = 2'd3;

endpackage

// File: rtl/ev21g1_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones
// instead of wrapping. Clear takes priority over enable.
module ev21g1_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, otherwise increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared asynchronously by the active-low system reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ev21g1_run_ctrl.sv
// Run controller between board clock/reset and the ev21g1 CPU core.
// Sequences the CPU reset, gates execution through a clock enable
// (free-run, bounded or single-step), counts executed cycles and halts on
// user stop, watchpoint match or cycle budget.
module ev21g1_run_ctrl
  import ev21g1_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int CNT_W        = 32,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic              stop,
  input  logic              mode,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic              watch_en,
  input  logic [DATA_W-1:0] watch_value,
  input  logic [DATA_W-1:0] watch_port,
  output logic              cpu_reset,
  output logic              cpu_clk_en,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              busy,
  output logic              done,
  output logic [1:0]        halt_cause
);

  // Wide enough to reach RESET_CYCLES so the hold counter can park there.
  localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  state_t            state_q, state_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic [1:0]        halt_cause_q, halt_cause_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;
  logic              restart;
  logic              hold_en;
  logic              count_en;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  count_next;
  logic              watch_hit;
  logic              budget_hit;

  assign hold_en    = (state_q == ST_RST_HOLD);
  assign count_en   = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign count_next = cycle_count + {{(CNT_W-1){1'b0}}, 1'b1};
  assign watch_hit  = watch_en && (watch_port == watch_value);
  assign budget_hit = mode_q && (count_next == run_cycles_q);

  ev21g1_sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (hold_en),
    .clr   (restart),
    .cnt   (hold_cnt)
  );

  ev21g1_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (count_en),
    .clr   (restart),
    .cnt   (cycle_count)
  );

  // Next-state, CPU reset, halt cause and run-parameter capture.
  always_comb begin
    state_d      = state_q;
    cpu_reset_d  = cpu_reset_q;
    halt_cause_d = halt_cause_q;
    mode_d       = mode_q;
    run_cycles_d = run_cycles_q;
    restart      = 1'b0;
    case (state_q)
      ST_RST_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_d     = ST_IDLE;
          cpu_reset_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (start) begin
          mode_d       = mode;
          run_cycles_d = run_cycles;
          if (mode && (run_cycles == '0)) begin
            state_d      = ST_HALTED;
            halt_cause_d = HALT_BUDGET;
          end else begin
            state_d = ST_RUN;
          end
        end else if (step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d      = ST_HALTED;
          halt_cause_d = HALT_USER;
        end else if (watch_hit) begin
          state_d      = ST_HALTED;
          halt_cause_d = HALT_WATCH;
        end else if (budget_hit) begin
          state_d      = ST_HALTED;
          halt_cause_d = HALT_BUDGET;
        end
      end
      ST_STEP: begin
        state_d = ST_IDLE;
      end
      ST_HALTED: begin
        if (start) begin
          state_d      = ST_RST_HOLD;
          cpu_reset_d  = 1'b0;
          halt_cause_d = HALT_NONE;
          restart      = 1'b1;
        end
      end
      default: begin
        state_d = ST_RST_HOLD;
      end
    endcase
  end

  // Controller registers; reset drops the CPU clock enable immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RST_HOLD;
      cpu_reset_q  <= 1'b0;
      halt_cause_q <= HALT_NONE;
      mode_q       <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      cpu_reset_q  <= cpu_reset_d;
      halt_cause_q <= halt_cause_d;
      mode_q       <= mode_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign cpu_reset  = cpu_reset_q;
  assign cpu_clk_en = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign busy       = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign done       = (state_q == ST_HALTED);
  assign halt_cause = halt_cause_q;

endmodule
